// File: rtl/hs32_mem_arb_if.sv
// hs32_mem_arb_if: fetch, execute and memory-side signals of the HS32 memory arbiter.
// The master modport is the arbiter view. The slave modport is the view of the
// surrounding pipeline and memory.
interface hs32_mem_arb_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   // fetch port (read-only)
   logic [AW-1:0] addr_f;
   logic          stb_f;
   logic          ack_f;
   logic          stl_f;
   logic [DW-1:0] dtr_f;
   logic          flush;

   // execute port
   logic [AW-1:0] addr_e;
   logic [DW-1:0] dtw_e;
   logic          rw_e;
   logic          stb_e;
   logic          ack_e;
   logic          stl_e;
   logic [DW-1:0] dtr_e;

   // memory side
   logic [AW-1:0] addr_m;
   logic [DW-1:0] dtw_m;
   logic          rw_m;
   logic          stbm;
   logic [DW-1:0] dtr_m;
   logic          ackm;
   logic          stlm;

   modport master (
      input  addr_f, stb_f, flush,
      input  addr_e, dtw_e, rw_e, stb_e,
      input  dtr_m, ackm, stlm,
      output ack_f, stl_f, dtr_f,
      output ack_e, stl_e, dtr_e,
      output addr_m, dtw_m, rw_m, stbm
   );

   modport slave (
      output addr_f, stb_f, flush,
      output addr_e, dtw_e, rw_e, stb_e,
      output dtr_m, ackm, stlm,
      input  ack_f, stl_f, dtr_f,
      input  ack_e, stl_e, dtr_e,
      input  addr_m, dtw_m, rw_m, stbm
   );
endinterface

// File: rtl/hs32_mem_arb.sv
// hs32_mem_arb: arbitrates the HS32 fetch and execute ports onto one memory port.
// Execute has priority. Losing or busy-time requests are stalled. Each memory
// transaction ends on ack, stall or timeout. A pipeline flush discards an
// outstanding fetch response.
module hs32_mem_arb #(
   parameter int unsigned TIMEOUT = 15
) (
   input logic            clk,
   input logic            reset,
   hs32_mem_arb_if.master bus
);
   localparam int unsigned CNT_W = 8;
   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_F  = 2'd1,
      BUSY_E  = 2'd2,
      DISCARD = 2'd3
   } state_t;

   state_t            r_state,  w_state_nxt;
   logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
   logic              r_stbm,   w_stbm_nxt;
   logic              r_ack_f,  w_ack_f_nxt;
   logic              r_stl_f,  w_stl_f_nxt;
   logic              r_ack_e,  w_ack_e_nxt;
   logic              r_stl_e,  w_stl_e_nxt;
   logic              r_rw_m,   w_rw_m_nxt;
   logic [AW-1:0]     r_addr_m, w_addr_m_nxt;
   logic [DW-1:0]     r_dtw_m,  w_dtw_m_nxt;
   logic [DW-1:0]     r_dtr_f,  w_dtr_f_nxt;
   logic [DW-1:0]     r_dtr_e,  w_dtr_e_nxt;

   // memory responses only count once the request strobe has dropped
   logic w_ack_ok;
   logic w_stl_ok;
   logic w_tmo;

   assign w_ack_ok = !r_stbm && bus.ackm;
   assign w_stl_ok = !r_stbm && bus.stlm && !bus.ackm;
   assign w_tmo    = (r_cnt == CNT_W'(TIMEOUT));

   // state register and all registered outputs (synchronous active-low reset)
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_stbm   <= 1'b0;
         r_ack_f  <= 1'b0;
         r_stl_f  <= 1'b0;
         r_ack_e  <= 1'b0;
         r_stl_e  <= 1'b0;
         r_rw_m   <= 1'b0;
         r_addr_m <= '0;
         r_dtw_m  <= '0;
         r_dtr_f  <= '0;
         r_dtr_e  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_stbm   <= w_stbm_nxt;
         r_ack_f  <= w_ack_f_nxt;
         r_stl_f  <= w_stl_f_nxt;
         r_ack_e  <= w_ack_e_nxt;
         r_stl_e  <= w_stl_e_nxt;
         r_rw_m   <= w_rw_m_nxt;
         r_addr_m <= w_addr_m_nxt;
         r_dtw_m  <= w_dtw_m_nxt;
         r_dtr_f  <= w_dtr_f_nxt;
         r_dtr_e  <= w_dtr_e_nxt;
      end
   end

   // next-state, request latching and one-cycle response pulses
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_stbm_nxt   = 1'b0;
      w_ack_f_nxt  = 1'b0;
      w_stl_f_nxt  = 1'b0;
      w_ack_e_nxt  = 1'b0;
      w_stl_e_nxt  = 1'b0;
      w_rw_m_nxt   = r_rw_m;
      w_addr_m_nxt = r_addr_m;
      w_dtw_m_nxt  = r_dtw_m;
      w_dtr_f_nxt  = r_dtr_f;
      w_dtr_e_nxt  = r_dtr_e;

      unique case (r_state)
         IDLE: begin
            if (bus.stb_e) begin
               w_addr_m_nxt = bus.addr_e;
               w_dtw_m_nxt  = bus.dtw_e;
               w_rw_m_nxt   = bus.rw_e;
               w_stbm_nxt   = 1'b1;
               w_cnt_nxt    = '0;
               w_stl_f_nxt  = bus.stb_f;
               w_state_nxt  = BUSY_E;
            end else if (bus.stb_f) begin
               w_addr_m_nxt = bus.addr_f;
               w_dtw_m_nxt  = '0;
               w_rw_m_nxt   = 1'b0;
               w_stbm_nxt   = 1'b1;
               w_cnt_nxt    = '0;
               w_state_nxt  = BUSY_F;
            end
         end

         BUSY_F: begin
            w_stl_e_nxt = bus.stb_e;
            w_stl_f_nxt = bus.stb_f;
            if (w_ack_ok) begin
               if (!bus.flush) begin
                  w_ack_f_nxt = 1'b1;
                  w_dtr_f_nxt = bus.dtr_m;
               end
               w_state_nxt = IDLE;
            end else if (w_stl_ok || w_tmo) begin
               w_stl_f_nxt = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (bus.flush) begin
                  w_state_nxt = DISCARD;
               end
            end
         end

         BUSY_E: begin
            w_stl_e_nxt = bus.stb_e;
            w_stl_f_nxt = bus.stb_f;
            if (w_ack_ok) begin
               w_ack_e_nxt = 1'b1;
               w_dtr_e_nxt = bus.dtr_m;
               w_state_nxt = IDLE;
            end else if (w_stl_ok || w_tmo) begin
               w_stl_e_nxt = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         DISCARD: begin
            w_stl_e_nxt = bus.stb_e;
            w_stl_f_nxt = bus.stb_f;
            if (w_ack_ok || w_stl_ok || w_tmo) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // a flush cancels any fetch-side response due in the following cycle
      if (bus.flush) begin
         w_ack_f_nxt = 1'b0;
         w_stl_f_nxt = 1'b0;
      end
   end

   assign bus.stbm   = r_stbm;
   assign bus.addr_m = r_addr_m;
   assign bus.dtw_m  = r_dtw_m;
   assign bus.rw_m   = r_rw_m;
   assign bus.ack_f  = r_ack_f;
   assign bus.stl_f  = r_stl_f;
   assign bus.dtr_f  = r_dtr_f;
   assign bus.ack_e  = r_ack_e;
   assign bus.stl_e  = r_stl_e;
   assign bus.dtr_e  = r_dtr_e;

endmodule

// File: doc/hs32_mem_arb.md
HS32_MEM_ARB -- requirements
Module: hs32_mem_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the number of cycles without slave ack/stl before the arbiter aborts a transaction (range 1..255).
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port addr_f, input, 32, fetch-port address (read-only port).
REQ-005 SHALL have port stb_f, input, 1, fetch-port request pulse.
REQ-006 SHALL have port ack_f / stl_f / dtr_f, output, 1/1/32, fetch-port completion, stall and read data.
REQ-007 SHALL have port flush, input, 1, pipeline flush; discards any in-flight fetch response.
REQ-008 SHALL have port addr_e / dtw_e / rw_e / stb_e, input, 32/32/1/1, execute-port address, write data, write enable (1 = write) and request pulse.
REQ-009 SHALL have port ack_e / stl_e / dtr_e, output, 1/1/32, execute-port completion, stall and read data.
REQ-010 SHALL have port addr_m / dtw_m / rw_m / stbm, output, 32/32/1/1, memory-side address, write data, write enable and request pulse.
REQ-011 SHALL have port dtr_m / ackm / stlm, input, 32/1/1, memory-side read data, completion and stall.

Function
REQ-012 SHALL implement FSM IDLE, BUSY_F, BUSY_E, DISCARD; all master-side outputs registered.
REQ-013 SHALL, in IDLE with stb_e=1, latch the execute request, drive stbm=1 for exactly one cycle in the next cycle, and enter BUSY_E.
REQ-014 SHALL, in IDLE with stb_f=1 and stb_e=0, latch the fetch request, pulse stbm, and enter BUSY_F.
REQ-015 SHALL, when stb_e and stb_f are both 1 in IDLE, grant execute and pulse stl_f for one cycle in the next cycle.
REQ-016 SHALL, for any stb_x arriving in a non-IDLE state, pulse stl_x for one cycle in the next cycle; the active transaction is unaffected.
REQ-017 SHALL hold addr_m/dtw_m/rw_m stable from the stbm cycle until ackm, stlm or timeout; rw_m=0 always for fetch.
REQ-018 SHALL, on ackm in BUSY_x: assert ack_x for one cycle on the next cycle, with dtr_x = dtr_m captured at ackm; return to IDLE.
REQ-019 SHALL, on stlm in BUSY_x: pulse stl_x for one cycle on the next cycle; return to IDLE.
REQ-020 SHALL ignore ackm/stlm in the same cycle stbm is high; they are sampled from the cycle after.
REQ-021 SHALL give ackm priority over stlm if both are asserted.
REQ-022 SHALL count cycles in BUSY_x/DISCARD with an 8-bit counter; on reaching TIMEOUT, pulse stl_x (no pulse in DISCARD) and return to IDLE.
REQ-023 SHALL, on flush in BUSY_F, enter DISCARD with no ack_f/stl_f for that transaction; DISCARD returns to IDLE on ackm, stlm or timeout.
REQ-024 SHALL leave flush with no effect in IDLE, BUSY_E and DISCARD, and suppress any ack_f/stl_f scheduled for the cycle after flush.
REQ-025 SHALL hold dtr_f/dtr_e at their last captured value when not acking.
REQ-026 SHALL take a new request in the cycle IDLE is re-entered (back-to-back: ack_x cycle and next stbm cycle may coincide).

Reset
REQ-027 SHALL, while reset=0 at a clock edge, enter IDLE and clear counter, stbm, ack_f, stl_f, ack_e, stl_e, rw_m, addr_m, dtw_m, dtr_f and dtr_e to 0.
REQ-028 SHALL abandon any in-flight transaction on reset without acking; a late ackm arriving in IDLE is ignored.

Verification
REQ-029 SHALL cover a fetch read: stb_f at T, addr_f=0x100, ackm at T+2 with dtr_m=0xDEADBEEF -> stbm at T+1, addr_m=0x100, rw_m=0, ack_f at T+3, dtr_f=0xDEADBEEF.
REQ-030 SHALL cover a collision: stb_f and stb_e (write 0x55 to 0x200) at T -> stbm at T+1 with rw_m=1, dtw_m=0x55; stl_f at T+1; ack_e after ackm.
REQ-031 SHALL cover flush mid-fetch: stb_f at T, flush at T+2, ackm at T+4 -> no ack_f, IDLE at T+5, stb_f at T+5 serviced normally.
REQ-032 SHALL cover timeout: TIMEOUT=4, stb_e at T, no ackm/stlm -> stl_e exactly once at T+6, then IDLE.
REQ-033 SHALL cover busy stall and memory stall: stb_f while BUSY_E -> stl_f next cycle; stlm in BUSY_F -> stl_f next cycle, no ack_f.
REQ-034 SHALL cover reset mid-BUSY_E -> all outputs 0, and a subsequent ackm produces no ack_e.
